// File: rtl/ascon_state_unloader.sv
// ascon_state_unloader: captures a slice of the ASCON state on load_i and streams it out
// one 64-bit word per valid/ready handshake. Define ASCON_UNLOAD_PARITY_EN to add parity_o.
package ascon_pack;
    typedef logic [63:0]   type_word;
    typedef type_word [4:0] type_state;
endpackage

module ascon_state_unloader
    import ascon_pack::*;
#(
    parameter int FIRST_WORD = 0,
    parameter int NB_WORDS   = 5
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  type_state   state_i,
    output logic        busy_o,
    output logic [63:0] word_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
`ifdef ASCON_UNLOAD_PARITY_EN
    output logic        parity_o,
`endif
    output logic        done_o
);

    localparam int IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int SLOTS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [63:0]      w_words [SLOTS];
    logic             w_capture;
    logic             w_advance;
    logic             w_last;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_index == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        valid_o      = 1'b0;
        last_o       = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_i) begin
                    w_capture    = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                last_o  = w_last;
                if (ready_i) begin
                    if (w_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                busy_o       = 1'b1;
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_index <= '0;
        end else if (w_capture) begin
            r_index <= '0;
        end else if (w_advance) begin
            r_index <= r_index + 1'b1;
        end
    end

    // Slots beyond NB_WORDS read as zero so every index value selects a defined word.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_word
        if (gi < NB_WORDS) begin : g_reg
            logic [63:0] r_word;
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    r_word <= '0;
                end else if (w_capture) begin
                    r_word <= state_i[FIRST_WORD + gi];
                end
            end
            assign w_words[gi] = r_word;
        end else begin : g_pad
            assign w_words[gi] = '0;
        end
    end

    assign word_o = valid_o ? w_words[r_index] : 64'h0;

`ifdef ASCON_UNLOAD_PARITY_EN
    assign parity_o = ^word_o;
`endif

endmodule

// File: tb/tb_ascon_state_unloader.sv
// Bench for ascon_state_unloader: two instances (default and FIRST_WORD=3/NB_WORDS=2) checked
// every cycle against a queue-style reference model under directed and random stimulus.
module tb_ascon_state_unloader;
    import ascon_pack::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load;
    logic        ready;
    type_state   st;

    logic        busy_a, valid_a, last_a, done_a;
    logic        busy_b, valid_b, last_b, done_b;
    logic [63:0] word_a, word_b;
`ifdef ASCON_UNLOAD_PARITY_EN
    logic        par_a, par_b;
`endif

    ascon_state_unloader #(.FIRST_WORD(0), .NB_WORDS(5)) dut_a (
        .clock_i (clk),
        .reset_i (rst),
        .load_i  (load),
        .state_i (st),
        .busy_o  (busy_a),
        .word_o  (word_a),
        .valid_o (valid_a),
        .ready_i (ready),
        .last_o  (last_a),
`ifdef ASCON_UNLOAD_PARITY_EN
        .parity_o(par_a),
`endif
        .done_o  (done_a)
    );

    ascon_state_unloader #(.FIRST_WORD(3), .NB_WORDS(2)) dut_b (
        .clock_i (clk),
        .reset_i (rst),
        .load_i  (load),
        .state_i (st),
        .busy_o  (busy_b),
        .word_o  (word_b),
        .valid_o (valid_b),
        .ready_i (ready),
        .last_o  (last_b),
`ifdef ASCON_UNLOAD_PARITY_EN
        .parity_o(par_b),
`endif
        .done_o  (done_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a list of words still owed to the sink plus a pending done pulse.
    logic [63:0] mw     [2][5];
    int          mhead  [2];
    int          mcount [2];
    bit          mdone  [2];
    int          first_of [2] = '{0, 3};
    int          nb_of    [2] = '{5, 2};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mcount[m] = 0;
                mhead[m]  = 0;
                mdone[m]  = 1'b0;
            end else if (mdone[m]) begin
                mdone[m] = 1'b0;
            end else if (mcount[m] > 0) begin
                if (ready) begin
                    $display("xfer %s word=%h", (m == 0) ? "a" : "b", mw[m][mhead[m]]);
                    mhead[m]++;
                    mcount[m]--;
                    if (mcount[m] == 0) mdone[m] = 1'b1;
                end
            end else if (load) begin
                for (int k = 0; k < nb_of[m]; k++) mw[m][k] = st[first_of[m] + k];
                mhead[m]  = 0;
                mcount[m] = nb_of[m];
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic        ev;
            logic [63:0] ew;
            string       p;
            p  = (m == 0) ? "a" : "b";
            ev = (mcount[m] > 0);
            ew = ev ? mw[m][mhead[m]] : 64'h0;
            check({p, ".valid"}, {63'b0, (m == 0) ? valid_a : valid_b}, {63'b0, ev});
            check({p, ".word"},  (m == 0) ? word_a : word_b, ew);
            check({p, ".last"},  {63'b0, (m == 0) ? last_a : last_b}, {63'b0, mcount[m] == 1});
            check({p, ".done"},  {63'b0, (m == 0) ? done_a : done_b}, {63'b0, mdone[m]});
            check({p, ".busy"},  {63'b0, (m == 0) ? busy_a : busy_b}, {63'b0, ev || mdone[m]});
`ifdef ASCON_UNLOAD_PARITY_EN
            check({p, ".parity"}, {63'b0, (m == 0) ? par_a : par_b}, {63'b0, ^ew});
`endif
        end
    endtask

    task automatic cycle(input logic l, input logic r, input logic rs);
        load  = l;
        ready = r;
        rst   = rs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 5; k++) st[k] = 64'(k + 1) << 60;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        ready = 1'b0;
        set_ramp();
        for (int m = 0; m < 2; m++) begin
            mhead[m]  = 0;
            mcount[m] = 0;
            mdone[m]  = 1'b0;
            for (int k = 0; k < 5; k++) mw[m][k] = 64'h0;
        end
        @(negedge clk);

        // reset, with load and ready asserted to confirm reset priority
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        // straight-through transfer
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);

        // back-pressure on word 2
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);

        // load during SEND with a changed state is ignored
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) st[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        set_ramp();

        // reset after word 3 is accepted, then a fresh load
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0);

        // odd/even parity words
        st[0] = 64'h7;
        st[1] = 64'h3;
        st[3] = 64'h7;
        st[4] = 64'h3;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 5; k++) st[k] = {$urandom, $urandom};
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
